// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: next-PC kinds, FSM states
// and the default reset vector.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

  // Upper two bits of npc_op; bit 0 is the branch-taken flag.
  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_JAL  = 2'b01,
    NPC_JALR = 2'b10,
    NPC_BR   = 2'b11
  } npc_kind_e;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    ERR    = 2'b10
  } state_e;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for sequential flow, JAL, JALR and
// conditional branches. All sums wrap modulo 2^32.
module npc_calc
  import ifu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] npc
);

  npc_kind_e   kind;
  logic        taken;
  logic [31:0] seq_target;
  logic [31:0] rel_target;
  logic [31:0] reg_target;

  assign kind       = npc_kind_e'(npc_op[2:1]);
  assign taken      = npc_op[0];
  assign seq_target = pc_inc(pc);
  assign rel_target = pc + imm;
  // JALR drops bit 0 of the computed target; bit 1 is left for the misalign check.
  assign reg_target = (rs1 + imm) & ~32'h1;

  always_comb begin
    npc = seq_target;
    case (kind)
      NPC_SEQ:  npc = seq_target;
      NPC_JAL:  npc = rel_target;
      NPC_JALR: npc = reg_target;
      NPC_BR:   npc = taken ? rel_target : seq_target;
      default:  npc = seq_target;
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch unit: fetches at pc, holds the word for
// decode until commit, then redirects or traps on a misaligned target.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  input  logic        commit,
  input  logic [2:0]  npc_op,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic        misalign,
  output logic [31:0] instret
);

  state_e      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        valid_reg, valid_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] instret_reg, instret_next;
  logic        req_reg, req_next;
  logic [31:0] npc;
  logic        accept;

  npc_calc u_npc_calc (
    .pc     (pc_reg),
    .npc_op (npc_op),
    .imm    (imm),
    .rs1    (rs1),
    .npc    (npc)
  );

  // The request is registered so it stays low while reset is held and rises
  // on the first edge afterwards; acks are only honoured against a live request.
  assign accept = (state_reg == FETCH) && req_reg && imem_ack;

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    inst_next     = inst_reg;
    valid_next    = valid_reg;
    misalign_next = misalign_reg;
    instret_next  = instret_reg;
    req_next      = req_reg;
    case (state_reg)
      FETCH: begin
        req_next = 1'b1;
        if (accept) begin
          state_next = DECODE;
          inst_next  = imem_rdata;
          valid_next = 1'b1;
          req_next   = 1'b0;
        end
      end
      DECODE: begin
        req_next = 1'b0;
        if (commit) begin
          instret_next = instret_reg + 32'd1;
          valid_next   = 1'b0;
          if (npc[1:0] == 2'b00) begin
            pc_next    = npc;
            state_next = FETCH;
            req_next   = 1'b1;
          end else begin
            misalign_next = 1'b1;
            state_next    = ERR;
          end
        end
      end
      ERR: begin
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
      default: begin
        state_next = ERR;
        req_next   = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      inst_reg     <= 32'h0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      instret_reg  <= 32'h0;
      req_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      inst_reg     <= inst_next;
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
      instret_reg  <= instret_next;
      req_reg      <= req_next;
    end
  end

  assign imem_req   = req_reg;
  assign imem_addr  = pc_reg;
  assign inst_valid = valid_reg;
  assign inst       = inst_reg;
  assign inst_pc    = pc_reg;
  assign pc_plus4   = pc_inc(pc_reg);
  assign misalign   = misalign_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a transaction-level model tracks the expected
// architectural state and a negedge process compares every output each cycle.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        commit;
  logic [2:0]  npc_op;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        misalign;
  logic [31:0] instret;

  int checks_total = 0;
  int checks_passed = 0;
  int wait_cycles;
  int ack_cnt;
  logic spur_ack;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .pc_plus4   (pc_plus4),
    .commit     (commit),
    .npc_op     (npc_op),
    .imm        (imm),
    .rs1        (rs1),
    .misalign   (misalign),
    .instret    (instret)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Instruction memory with a programmable ack latency.
  assign imem_ack   = (imem_req && (ack_cnt >= wait_cycles)) || spur_ack;
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ack_cnt <= 0;
    else if (imem_req && !imem_ack) ack_cnt <= ack_cnt + 1;
    else                            ack_cnt <= 0;
  end

  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [2:0] op,
                                          input logic [31:0] im, input logic [31:0] r1);
    case (op)
      3'b010, 3'b011, 3'b111: return pc + im;
      3'b100, 3'b101:         return (r1 + im) & 32'hFFFF_FFFE;
      default:                return pc + 32'd4;
    endcase
  endfunction

  // Behavioural model: waiting-for-instruction / holding-instruction / trapped.
  logic [31:0] m_pc, m_inst, m_instret;
  logic        m_req, m_valid, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_inst <= 32'h0; m_instret <= 32'h0;
      m_req <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0;
    end else if (m_err) begin
      m_req <= 1'b0;
    end else if (!m_valid) begin
      if (m_req && imem_ack) begin
        m_valid <= 1'b1;
        m_inst  <= mem_word(m_pc);
        m_req   <= 1'b0;
      end else begin
        m_req <= 1'b1;
      end
    end else if (commit) begin
      m_instret <= m_instret + 32'd1;
      m_valid   <= 1'b0;
      if (ref_npc(m_pc, npc_op, imm, rs1) % 4 == 0) begin
        m_pc  <= ref_npc(m_pc, npc_op, imm, rs1);
        m_req <= 1'b1;
      end else begin
        m_err <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_req", {31'h0, imem_req}, {31'h0, m_req});
      if (m_req) chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", {31'h0, inst_valid}, {31'h0, m_valid});
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instret", instret, m_instret);
      chk("misalign", {31'h0, misalign}, {31'h0, m_err});
    end
  end

  task automatic wait_valid(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (inst_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks_total++;
      $display("FAIL wait_valid: inst_valid still 0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic do_commit(input logic [2:0] op, input logic [31:0] im, input logic [31:0] r1);
    commit = 1'b1; npc_op = op; imm = im; rs1 = r1;
    @(posedge clk); #1;
    commit = 1'b0;
    $display("commit op=%b imm=%h rs1=%h -> addr=%h req=%b instret=%0d misalign=%b",
             op, im, r1, imem_addr, imem_req, instret, misalign);
  endtask

  initial begin
    rst_n = 1'b0; commit = 1'b0; npc_op = 3'b000; imm = 32'h0; rs1 = 32'h0;
    wait_cycles = 0; spur_ack = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    chk("reset_req", {31'h0, imem_req}, 32'h0);
    chk("reset_instret", instret, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid_low", {31'h0, inst_valid}, 32'h0);
    @(posedge clk); #1;
    chk("first_valid", {31'h0, inst_valid}, 32'h1);
    chk("first_inst", inst, 32'h0050_0093);
    $display("fetch addr=%h inst=%h", inst_pc, inst);

    do_commit(3'b010, 32'h10, 32'h0);
    chk("jal_to_10", imem_addr, 32'h10);
    wait_valid(10);
    do_commit(3'b000, 32'h0, 32'h0);
    chk("seq_addr", imem_addr, 32'h14);
    chk("seq_instret", instret, 32'd2);
    wait_valid(10);
    do_commit(3'b011, 32'h0C, 32'h0);
    chk("jal_to_20", imem_addr, 32'h20);
    wait_valid(10);
    do_commit(3'b111, 32'hFFFF_FFF8, 32'h0);
    chk("br_taken", imem_addr, 32'h18);
    wait_valid(10);
    do_commit(3'b010, 32'h8, 32'h0);
    wait_valid(10);
    do_commit(3'b110, 32'hFFFF_FFF8, 32'h0);
    chk("br_not_taken", imem_addr, 32'h24);
    wait_valid(10);
    wait_cycles = 5;
    do_commit(3'b100, 32'h3, 32'h101);
    chk("jalr_addr", imem_addr, 32'h104);

    // Slow memory with spurious commits while the request is outstanding.
    commit = 1'b1; npc_op = 3'b010; imm = 32'h100;
    repeat (2) @(posedge clk); #1;
    commit = 1'b0;
    chk("spur_commit_instret", instret, 32'd7);
    chk("spur_commit_addr", imem_addr, 32'h104);
    chk("slow_req_held", {31'h0, imem_req}, 32'h1);
    wait_valid(12);
    chk("slow_inst", inst, mem_word(32'h104));

    // Spurious ack while holding an instruction for decode.
    spur_ack = 1'b1;
    @(posedge clk); #1;
    spur_ack = 1'b0;
    chk("spur_ack_valid", {31'h0, inst_valid}, 32'h1);

    do_commit(3'b101, 32'h0, 32'h80);
    chk("jalr_80", imem_addr, 32'h80);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'h0, imem_req}, 32'h0);
    chk("async_pc", inst_pc, 32'h0);
    chk("async_instret", instret, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles = 0;
    @(posedge clk); #1;
    chk("post_reset_req", {31'h0, imem_req}, 32'h1);
    chk("post_reset_addr", imem_addr, 32'h0);
    wait_valid(10);
    do_commit(3'b010, 32'h40, 32'h0);
    wait_valid(10);
    do_commit(3'b010, 32'h6, 32'h0);
    chk("err_misalign", {31'h0, misalign}, 32'h1);
    chk("err_req", {31'h0, imem_req}, 32'h0);
    chk("err_pc", inst_pc, 32'h40);
    chk("err_instret", instret, 32'd2);

    commit = 1'b1; npc_op = 3'b000;
    repeat (3) @(posedge clk); #1;
    commit = 1'b0;
    chk("err_commit_ignored", instret, 32'd2);
    chk("err_valid", {31'h0, inst_valid}, 32'h0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. Ports, in order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address.
- imem_ack  in  1  read-data valid; one outstanding request max.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst, inst_pc and pc_plus4 are valid for decode.
- inst  out  32  instruction to the control decoder.
- inst_pc  out  32  PC of inst.
- pc_plus4  out  32  inst_pc+4, link value for JAL/JALR write-back.
- commit  in  1  current instruction resolved; npc_op, imm and rs1 are valid.
- npc_op  in  3  {kind[1:0], branch}: 00x seq, 01x JAL, 10x JALR, 110 branch not taken, 111 branch taken.
- imm  in  32  sign-extended immediate.
- rs1  in  32  rs1 value, used by JALR.
- misalign  out  1  sticky target-misaligned error.
- instret  out  32  committed-instruction count.

Function
REQ-003 States SHALL be FETCH, DECODE and ERR; reset enters FETCH.
REQ-004 FETCH: imem_req=1 and imem_addr=pc; both SHALL stay stable until imem_ack is sampled high.
REQ-005 When imem_ack=1 in FETCH, the block SHALL register imem_rdata into inst and enter DECODE; inst_valid=1 from the next cycle.
REQ-006 DECODE: imem_req=0; inst, inst_pc and pc_plus4 SHALL hold stable until commit.
REQ-007 imem_ack outside FETCH and commit outside DECODE SHALL be ignored.
REQ-008 On commit in DECODE, npc SHALL be:
- pc+4 for 000, 001 and 110.
- pc+imm for 010, 011 and 111.
- (rs1+imm)&~32'h1 for 100 and 101.
- All arithmetic is modulo 2^32; wrap-around is silent.
REQ-009 If npc[1:0]==2'b00: pc<=npc, instret<=instret+1, inst_valid<=0, next state FETCH. The new fetch starts the cycle after commit (minimum 2 cycles per instruction with zero-wait memory).
REQ-010 If npc[1:0]!=2'b00: pc SHALL remain unchanged and instret<=instret+1. State goes to ERR with misalign=1 and inst_valid=0.
REQ-011 ERR SHALL be terminal until reset: imem_req=0, inst_valid=0, and commit is ignored.
REQ-012 instret SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-013 inst_pc SHALL equal pc; pc_plus4 SHALL equal pc+4, combinational from the pc register.

Reset
REQ-014 Asserting rst_n=0 SHALL asynchronously set:
- pc=RESET_PC and state=FETCH.
- inst=0, inst_valid=0, misalign=0, instret=0.
- imem_req=0 while reset is held.
REQ-015 Reset mid-FETCH SHALL abandon the outstanding request. An imem_ack arriving after deassertion for the abandoned request is outside the block's contract; the memory drops it on reset.
REQ-016 After deassertion, imem_req SHALL rise on the first clock edge with imem_addr=RESET_PC.

Structure
REQ-017 Shared package ifu_pkg SHALL hold:
- the npc_op encodings (NPC_SEQ=2'b00, NPC_JAL=2'b01, NPC_JALR=2'b10, NPC_BR=2'b11);
- the state enum {FETCH, DECODE, ERR};
- the default RESET_PC.
REQ-018 Next-PC arithmetic SHALL live in one combinational sub-module, npc_calc (inputs pc, npc_op, imm, rs1; output npc). The state machine and registers stay in ifu_fetch.

Verification
REQ-019 Reset, RESET_PC=0, zero-wait memory returning 32'h00500093 -> imem_addr=0; inst_valid=1 two cycles after reset release; inst=32'h00500093.
REQ-020 Commit with npc_op=000 at pc=0x10 -> next imem_addr=0x14; instret increments by 1.
REQ-021 Commit branch taken, npc_op=111, pc=0x20, imm=-8 -> imem_addr=0x18. Commit branch not taken, npc_op=110 -> imem_addr=0x24.
REQ-022 JALR, npc_op=100, rs1=0x101, imm=0x3 -> imem_addr=0x104. JAL, npc_op=010, pc=0x40, imm=0x6 -> misalign=1, ERR entered, imem_req=0 thereafter.
REQ-023 imem_ack delayed 5 cycles -> imem_req and imem_addr stable throughout. A spurious commit during FETCH -> no pc or instret change.
REQ-024 rst_n pulsed low mid-FETCH at pc=0x80 -> outputs reset immediately; the next request is at imem_addr=RESET_PC.
